// File: rtl/slow_adc_seq_avg_if.sv
// Pin-level bundle between the sequencer and a group of slow SPI ADCs.
// CNV, SCK and SDI are shared by all chips. CS_n, SDO and BUSY are one bit per chip.
interface slow_adc_seq_avg_if #(
    parameter int N_ADC = 2
);
    logic             cnv;
    logic             sck;
    logic             sdi;
    logic [N_ADC-1:0] cs_n;
    logic [N_ADC-1:0] sdo;
    logic [N_ADC-1:0] busy;

    modport master (output cnv, sck, sdi, cs_n, input sdo, busy);
    modport slave  (input cnv, sck, sdi, cs_n, output sdo, busy);
endinterface

// File: rtl/slow_adc_seq_avg.sv
// Slow-ADC sequencer with boxcar averaging.
// Each period it starts a conversion on all chips and reads back the result of slot k.
// While it reads, it shifts out the configuration word for slot k+1.
// It averages 2^AVG_LOG2 sequences before it publishes one frame.
module slow_adc_seq_avg #(
    parameter int N_ADC    = 2,
    parameter int RES      = 16,
    parameter int N_SEQ    = 8,
    parameter int T_CONV   = 100,
    parameter int N_CNV    = 5,
    parameter int SCK_DIV  = 2,
    parameter int AVG_LOG2 = 2,
    parameter int BUSY_TO  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [3*N_SEQ-1:0]         seq,
    input  logic                       err_clr,
    slow_adc_seq_avg_if.master         adc,
    output logic [N_ADC*N_SEQ*RES-1:0] data_out,
    output logic                       frame_valid,
    output logic                       timeout_err
);
    localparam int ACC_W = RES + AVG_LOG2;
    localparam int NAVG  = 1 << AVG_LOG2;
    localparam int KW    = (N_SEQ > 1) ? $clog2(N_SEQ) : 1;
    localparam int SW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CMAX  = (N_CNV > BUSY_TO) ? N_CNV : BUSY_TO;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int PW    = $clog2(T_CONV + 1);
    localparam int DW    = $clog2(SCK_DIV + 1);
    localparam int BW    = $clog2(RES + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_CNV_LO, S_SHIFT, S_STORE} state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            per_q, per_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DW-1:0]            div_q, div_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [KW-1:0]            k_q, k_d, k_next;
    logic [SW-1:0]            sc_q, sc_d;
    logic                     cnv_q, cnv_d, sck_q, sck_d, sdi_q, sdi_d, csn_q, csn_d;
    logic                     fv_q, fv_d, terr_q, terr_d, en_q;
    logic [RES-1:0]           cfg_q, cfg_d;
    logic [RES-1:0]           sh_q [N_ADC];
    logic [RES-1:0]           sh_d [N_ADC];
    logic signed [ACC_W-1:0]  acc_q [N_ADC][N_SEQ];
    logic signed [ACC_W-1:0]  acc_d [N_ADC][N_SEQ];
    logic [N_ADC*N_SEQ*RES-1:0] data_q, data_d;
    logic                     wrap, timeout;

    assign k_next = (k_q == KW'(N_SEQ - 1)) ? '0 : k_q + KW'(1);

    // Next-state logic: period timer, conversion FSM, SPI shifter, accumulate and publish.
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        k_d     = k_q;
        sc_d    = sc_q;
        sck_d   = sck_q;
        sdi_d   = sdi_q;
        cfg_d   = cfg_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        data_d  = data_q;
        fv_d    = 1'b0;
        terr_d  = terr_q;
        wrap    = 1'b0;
        timeout = 1'b0;

        if (en) begin
            if (per_q == PW'(T_CONV - 1)) begin
                per_d = '0;
                wrap  = 1'b1;
            end else begin
                per_d = per_q + PW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (wrap) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CW'(N_CNV - 1)) begin
                    state_d = S_CNV_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CNV_LO: begin
                if (adc.busy == '0) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    cfg_d   = '0;
                    cfg_d[RES-1 -: 3] = seq[3*k_next +: 3];
                    sdi_d   = seq[3*k_next + 2];
                end else if (cnt_q == CW'(BUSY_TO - 1)) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                // bit_q counts falling edges. CS_n is released one cycle after the last one.
                if (bit_q == BW'(RES)) begin
                    state_d = S_STORE;
                end else if (div_q == DW'(SCK_DIV - 1)) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        for (int unsigned a = 0; a < N_ADC; a++)
                            sh_d[a] = {sh_q[a][RES-2:0], adc.sdo[a]};
                    end else begin
                        cfg_d = cfg_q << 1;
                        sdi_d = cfg_q[RES-2];
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_STORE: begin
                state_d = S_IDLE;
                for (int unsigned a = 0; a < N_ADC; a++)
                    acc_d[a][k_q] = acc_q[a][k_q] + ACC_W'(signed'(sh_q[a]));
                k_d = k_next;
                if (k_q == KW'(N_SEQ - 1)) begin
                    if (sc_q == SW'(NAVG - 1)) begin
                        sc_d = '0;
                        fv_d = 1'b1;
                        for (int unsigned a = 0; a < N_ADC; a++) begin
                            for (int unsigned s = 0; s < N_SEQ; s++) begin
                                data_d[(a*N_SEQ + s)*RES +: RES] = RES'(acc_d[a][s] >>> AVG_LOG2);
                                acc_d[a][s] = '0;
                            end
                        end
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh enable restarts the averaging window from slot 0; published data is kept.
        if (en && !en_q) begin
            k_d  = '0;
            sc_d = '0;
            for (int unsigned a = 0; a < N_ADC; a++)
                for (int unsigned s = 0; s < N_SEQ; s++)
                    acc_d[a][s] = '0;
        end

        if (timeout)      terr_d = 1'b1;
        else if (err_clr) terr_d = 1'b0;

        cnv_d = (state_d == S_START);
        csn_d = (state_d != S_SHIFT);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            per_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            k_q     <= '0;
            sc_q    <= '0;
            cnv_q   <= 1'b0;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            csn_q   <= 1'b1;
            fv_q    <= 1'b0;
            terr_q  <= 1'b0;
            en_q    <= 1'b0;
            cfg_q   <= '0;
            data_q  <= '0;
            for (int unsigned a = 0; a < N_ADC; a++) begin
                sh_q[a] <= '0;
                for (int unsigned s = 0; s < N_SEQ; s++)
                    acc_q[a][s] <= '0;
            end
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            k_q     <= k_d;
            sc_q    <= sc_d;
            cnv_q   <= cnv_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            csn_q   <= csn_d;
            fv_q    <= fv_d;
            terr_q  <= terr_d;
            en_q    <= en;
            cfg_q   <= cfg_d;
            data_q  <= data_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
        end
    end

    assign adc.cnv     = cnv_q;
    assign adc.sck     = sck_q;
    assign adc.sdi     = sdi_q;
    assign adc.cs_n    = {N_ADC{csn_q}};
    assign data_out    = data_q;
    assign frame_valid = fv_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_slow_adc_seq_avg.sv
// Bench for slow_adc_seq_avg.
// It contains a behavioural ADC pin model and a slot/window reference model.
module tb_slow_adc_seq_avg;
    localparam int N_ADC = 2, RES = 16, N_SEQ = 4, AVG_LOG2 = 2, NAVG = 4;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, err_clr = 1'b0;
    logic [3*N_SEQ-1:0] seq = '0;
    logic [N_ADC*N_SEQ*RES-1:0] data_out;
    logic frame_valid, timeout_err;

    slow_adc_seq_avg_if #(.N_ADC(N_ADC)) adc_if ();

    slow_adc_seq_avg #(
        .N_ADC(N_ADC), .RES(RES), .N_SEQ(N_SEQ), .T_CONV(100), .N_CNV(5),
        .SCK_DIV(2), .AVG_LOG2(AVG_LOG2), .BUSY_TO(64)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .seq(seq), .err_clr(err_clr), .adc(adc_if),
        .data_out(data_out), .frame_valid(frame_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // ADC busy: rises with CNV and clears 10 cycles after CNV drops, unless forced.
    int   busy_cnt = 0;
    logic busy_force = 1'b0;
    always @(posedge clk) begin
        if (adc_if.cnv) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign adc_if.busy = {N_ADC{busy_force || (busy_cnt != 0)}};

    // ADC serial model and bus monitor, both sampled mid-cycle.
    logic [RES-1:0]   adc_word [N_ADC];
    logic [RES-1:0]   sh_m [N_ADC];
    logic [N_ADC-1:0] sdo_v = '0;
    logic [RES-1:0]   cap_word = '0;
    logic             prev_csn = 1'b1, prev_sck = 1'b0, prev_sdi = 1'b0;
    int rise_cnt = 0, csn_falls = 0, fv_cnt = 0, sdi_bad = 0;
    assign adc_if.sdo = sdo_v;

    always @(negedge clk) begin
        if (prev_csn && adc_if.cs_n[0] === 1'b0) begin
            cap_word = '0;
            rise_cnt = 0;
            csn_falls++;
            for (int a = 0; a < N_ADC; a++) begin
                sh_m[a]  = adc_word[a];
                sdo_v[a] = adc_word[a][RES-1];
            end
        end else if (!prev_csn && adc_if.cs_n[0] === 1'b0) begin
            if (!prev_sck && adc_if.sck) begin
                cap_word = {cap_word[RES-2:0], adc_if.sdi};
                rise_cnt++;
            end
            if (prev_sck && !adc_if.sck) begin
                for (int a = 0; a < N_ADC; a++) begin
                    sh_m[a]  = sh_m[a] << 1;
                    sdo_v[a] = sh_m[a][RES-1];
                end
            end
            if (adc_if.sdi !== prev_sdi && !(prev_sck && !adc_if.sck)) sdi_bad++;
        end
        if (frame_valid === 1'b1) fv_cnt++;
        prev_csn = adc_if.cs_n[0];
        prev_sck = adc_if.sck;
        prev_sdi = adc_if.sdi;
    end

    // Reference model: slot index, window count, running sums and published words.
    int             m_k = 0, m_sc = 0;
    int             m_sum [N_ADC][N_SEQ];
    logic [RES-1:0] m_data [N_ADC][N_SEQ];
    logic [RES-1:0] last_cfg;

    function automatic int floor_avg(input int x);
        return (x - (((x % NAVG) + NAVG) % NAVG)) / NAVG;
    endfunction

    function automatic logic [N_ADC*N_SEQ*RES-1:0] exp_vec();
        logic [N_ADC*N_SEQ*RES-1:0] v;
        for (int a = 0; a < N_ADC; a++)
            for (int s = 0; s < N_SEQ; s++)
                v[(a*N_SEQ + s)*RES +: RES] = m_data[a][s];
        return v;
    endfunction

    task automatic model_restart(input bit clear_data);
        m_k  = 0;
        m_sc = 0;
        for (int a = 0; a < N_ADC; a++)
            for (int s = 0; s < N_SEQ; s++) begin
                m_sum[a][s] = 0;
                if (clear_data) m_data[a][s] = '0;
            end
    endtask

    // One full conversion: load the ADC words, follow it on the bus, then check it against the model.
    task automatic run_conv(input logic [RES-1:0] w0, input logic [RES-1:0] w1);
        int n;
        int fv0;
        int exp_fv;
        logic [RES-1:0] exp_cfg;
        adc_word[0] = w0;
        adc_word[1] = w1;
        fv0 = fv_cnt;
        exp_fv = 0;
        n = 0;
        while (adc_if.cs_n[0] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (adc_if.cs_n[0] !== 1'b0) begin
            errors++; $display("FAIL conv_start: cs_n=%b required 0 within 400 cycles", adc_if.cs_n[0]);
        end
        n = 0;
        while (adc_if.cs_n[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (adc_if.cs_n[0] !== 1'b1) begin
            errors++; $display("FAIL conv_end: cs_n=%b required 1 within 200 cycles", adc_if.cs_n[0]);
        end
        repeat (2) @(negedge clk);

        exp_cfg = '0;
        exp_cfg[RES-1 -: 3] = seq[3*((m_k + 1) % N_SEQ) +: 3];
        last_cfg = cap_word;
        checks++;
        if (cap_word !== exp_cfg) begin
            errors++; $display("FAIL cfg_word slot %0d: got %h required %h", m_k, cap_word, exp_cfg);
        end
        checks++;
        if (rise_cnt !== RES) begin
            errors++; $display("FAIL sck_rises: got %0d required %0d", rise_cnt, RES);
        end

        for (int a = 0; a < N_ADC; a++)
            m_sum[a][m_k] += int'(signed'(adc_word[a]));
        m_k++;
        if (m_k == N_SEQ) begin
            m_k = 0;
            m_sc++;
            if (m_sc == NAVG) begin
                m_sc = 0;
                exp_fv = 1;
                for (int a = 0; a < N_ADC; a++)
                    for (int s = 0; s < N_SEQ; s++) begin
                        m_data[a][s] = RES'(floor_avg(m_sum[a][s]));
                        m_sum[a][s] = 0;
                    end
            end
        end
        checks++;
        if ((fv_cnt - fv0) !== exp_fv) begin
            errors++; $display("FAIL frame_valid_count: got %0d required %0d", fv_cnt - fv0, exp_fv);
        end
        checks++;
        if (data_out !== exp_vec()) begin
            errors++; $display("FAIL data_out: got %h required %h", data_out, exp_vec());
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (adc_if.cs_n !== '1) begin errors++; $display("FAIL rst_cs_n: got %b required 11", adc_if.cs_n); end
        checks++; if (adc_if.cnv !== 1'b0) begin errors++; $display("FAIL rst_cnv: got %b required 0", adc_if.cnv); end
        checks++; if (adc_if.sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b required 0", adc_if.sck); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", data_out); end
        checks++; if (frame_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got fv=%b terr=%b required 0 0", frame_valid, timeout_err);
        end
        model_restart(1'b1);
        rst = 1'b1;
        n = 0;
        while (adc_if.cnv !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 100) begin errors++; $display("FAIL first_cnv_cycle: got %0d required 100", n); end
        n = 0;
        while (adc_if.cnv === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 5) begin errors++; $display("FAIL cnv_width: got %0d required 5", n); end
    endtask

    task automatic test_extremes;
        for (int j = 0; j < N_SEQ*NAVG; j++) run_conv(16'h7FFF, 16'h8001);
        checks++; if (data_out[0 +: RES] !== 16'h7FFF) begin
            errors++; $display("FAIL max_pos: got %h required 7fff", data_out[0 +: RES]);
        end
        checks++; if (data_out[(N_SEQ + 3)*RES +: RES] !== 16'h8001) begin
            errors++; $display("FAIL max_neg: got %h required 8001", data_out[(N_SEQ + 3)*RES +: RES]);
        end
    endtask

    task automatic test_average;
        logic [RES-1:0] w0;
        for (int j = 0; j < N_SEQ*NAVG; j++) begin
            w0 = (m_k == 0) ? RES'(-(j/N_SEQ + 1)) : RES'($urandom);
            run_conv(w0, RES'($urandom));
        end
        checks++; if (data_out[0 +: RES] !== 16'hFFFD) begin
            errors++; $display("FAIL avg_floor: got %h required fffd", data_out[0 +: RES]);
        end
    endtask

    task automatic test_config;
        int k0;
        seq = 12'($urandom);
        seq[5:3] = 3'b101;
        for (int j = 0; j < N_SEQ; j++) begin
            k0 = m_k;
            run_conv(RES'($urandom), RES'($urandom));
            if (k0 == 0) begin
                checks++;
                if (last_cfg !== 16'hA000) begin
                    errors++; $display("FAIL cfg_slot1: got %h required a000", last_cfg);
                end
            end
        end
        checks++; if (sdi_bad !== 0) begin errors++; $display("FAIL sdi_edges: got %0d bad changes required 0", sdi_bad); end
    endtask

    task automatic test_timeout;
        int n;
        int f0;
        f0 = csn_falls;
        busy_force = 1'b1;
        n = 0;
        while (adc_if.cnv !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n = 0;
        while (adc_if.cnv === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        while (timeout_err !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b required 1", timeout_err); end
        checks++; if (n !== 64) begin errors++; $display("FAIL timeout_delay: got %0d required 64", n); end
        checks++; if (csn_falls !== f0) begin errors++; $display("FAIL timeout_no_cs: got %0d required %0d", csn_falls, f0); end
        busy_force = 1'b0;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b required 0", timeout_err); end
        run_conv(RES'($urandom), RES'($urandom));
    endtask

    task automatic test_enable;
        int f0;
        en = 1'b0;
        f0 = csn_falls;
        repeat (300) @(negedge clk);
        checks++; if (csn_falls !== f0) begin errors++; $display("FAIL en_off_idle: got %0d required %0d", csn_falls, f0); end
        checks++; if (data_out !== exp_vec()) begin errors++; $display("FAIL en_off_hold: got %h required %h", data_out, exp_vec()); end
        en = 1'b1;
        model_restart(1'b0);
        for (int j = 0; j < 3; j++) run_conv(RES'($urandom), RES'($urandom));
    endtask

    task automatic test_reset_midshift;
        int n;
        adc_word[0] = RES'($urandom);
        adc_word[1] = RES'($urandom);
        n = 0;
        while (adc_if.cs_n[0] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        n = 0;
        while (rise_cnt < 7 && n < 200) begin @(negedge clk); n++; end
        #1 rst = 1'b0;
        #1;
        checks++; if (adc_if.cs_n !== '1 || adc_if.sck !== 1'b0 || adc_if.cnv !== 1'b0 || adc_if.sdi !== 1'b0) begin
            errors++; $display("FAIL mid_rst_pins: got cs_n=%b sck=%b cnv=%b sdi=%b required 11 0 0 0",
                               adc_if.cs_n, adc_if.sck, adc_if.cnv, adc_if.sdi);
        end
        checks++; if (data_out !== '0 || frame_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL mid_rst_outs: got data=%h fv=%b terr=%b required 0 0 0", data_out, frame_valid, timeout_err);
        end
        model_restart(1'b1);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < N_SEQ*NAVG; j++) run_conv(RES'($urandom), RES'($urandom));
    endtask

    initial begin
        seq = 12'($urandom);
        adc_word[0] = '0;
        adc_word[1] = '0;
        test_reset;
        test_extremes;
        test_average;
        test_config;
        test_timeout;
        test_enable;
        test_reset_midshift;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
